// File: rtl/ram_lab_pkg.sv
// rtl/ram_lab_pkg.sv - shared types and defaults for the lab-3 RAM slice
//
// Purpose: widths shared by the RAM, the writer and the read checker, plus
// the read-checker FSM encoding.
// Ports: none (package).

package ram_lab_pkg;

  // Default geometry shared by the RAM, the writer and the checker.
  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 32;

  // Read-checker FSM, fixed encoding so the state is readable on a probe.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/ram_pattern_gen.sv
// rtl/ram_pattern_gen.sv - combinational fill-pattern generator
//
// Purpose: expected = SEED + addr*STEP, truncated to DATA_W bits. Shared by
// the writer and the read checker so both sides use one pattern definition.
// Ports:
//   addr      in   ADDR_W  word address
//   expected  out  DATA_W  pattern word for that address

module ram_pattern_gen
  import ram_lab_pkg::*;
#(
  parameter int                ADDR_W = RAM_ADDR_W,
  parameter int                DATA_W = RAM_DATA_W,
  parameter logic [DATA_W-1:0] SEED   = '0,
  parameter logic [DATA_W-1:0] STEP   = DATA_W'(1)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] expected
);

  logic [DATA_W-1:0] addr_ext;

  // Widen first so the product is formed at DATA_W bits and wraps there.
  assign addr_ext = DATA_W'(addr);
  assign expected = SEED + addr_ext * STEP;

endmodule

// File: rtl/ram_read_checker.sv
// rtl/ram_read_checker.sv - sweeps a sync RAM and checks it against the fill pattern
//
// Purpose: on start, reads addresses 0..DEPTH-1 (one per cycle), compares each
// returned word with SEED + addr*STEP, and reports error count, first failing
// address, a running word sum and a pass flag with a one-cycle done pulse.
// Ports:
//   clk             in   1       rising-edge clock
//   rst             in   1       synchronous reset, active-high
//   start           in   1       begins a sweep when idle
//   ram_en          out  1       RAM read enable
//   ram_addr        out  ADDR_W  RAM read address
//   ram_rdata       in   DATA_W  RAM read data, one cycle after ram_en
//   busy            out  1       sweep in progress
//   done            out  1       one-cycle pulse after the last word is checked
//   pass            out  1       err_cnt==0, valid with done, held until next start
//   err_cnt         out  ERR_W   saturating mismatch count
//   first_err_addr  out  ADDR_W  address of the first mismatch, 0 if none
//   sum             out  DATA_W  sum of all words read, wrapping

module ram_read_checker
  import ram_lab_pkg::*;
#(
  parameter int                ADDR_W = RAM_ADDR_W,
  parameter int                DEPTH  = 64,
  parameter int                DATA_W = RAM_DATA_W,
  parameter logic [DATA_W-1:0] SEED   = '0,
  parameter logic [DATA_W-1:0] STEP   = DATA_W'(1),
  parameter int                ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] sum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  chk_state_t        state;

  // Check stage: tracks which address the RAM is returning this cycle.
  logic              valid;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] expected;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;

  ram_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED),
    .STEP   (STEP)
  ) u_pattern (
    .addr     (chk_addr),
    .expected (expected)
  );

  assign mismatch = valid && (ram_rdata != expected);

  // Saturating count; also feeds pass so the final word is included.
  always_comb begin
    err_next = err_cnt;
    if (mismatch && (err_cnt != {ERR_W{1'b1}})) begin
      err_next = err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ram_en         <= 1'b0;
      ram_addr       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      sum            <= '0;
      valid          <= 1'b0;
      chk_addr       <= '0;
    end else begin
      valid    <= ram_en;
      chk_addr <= ram_addr;
      done     <= 1'b0;

      if (valid) begin
        sum     <= sum + ram_rdata;
        err_cnt <= err_next;
        // err_cnt never returns to zero within a sweep, so zero marks "first".
        if (mismatch && (err_cnt == '0)) begin
          first_err_addr <= chk_addr;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state          <= READ;
            ram_en         <= 1'b1;
            ram_addr       <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            sum            <= '0;
          end
        end
        READ: begin
          if (ram_addr == LAST_ADDR) begin
            state  <= DRAIN;
            ram_en <= 1'b0;
          end else begin
            ram_addr <= ram_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // The last word is being checked on this edge.
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_next == '0);
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_read_checker.sv
// tb/tb_ram_read_checker.sv - directed self-checking bench for ram_read_checker

module tb_ram_read_checker;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] start_v;

  int n_checks = 0;
  int n_err    = 0;

  // Instance A: default parameters.
  logic        a_en, a_busy, a_done, a_pass;
  logic [5:0]  a_addr, a_first;
  logic [31:0] a_rdata, a_sum;
  logic [7:0]  a_err;
  logic [31:0] mem_a [64];

  // Instance S: ERR_W=2, RAM returns all ones.
  logic        s_en, s_busy, s_done, s_pass;
  logic [5:0]  s_addr, s_first;
  logic [31:0] s_rdata, s_sum;
  logic [1:0]  s_err;

  // Instance D: DEPTH=1, SEED=5.
  logic        d_en, d_busy, d_done, d_pass;
  logic [5:0]  d_addr, d_first;
  logic [31:0] d_rdata, d_sum;
  logic [7:0]  d_err;

  ram_read_checker dut_a (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .ram_en(a_en), .ram_addr(a_addr),
    .ram_rdata(a_rdata), .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err),
    .first_err_addr(a_first), .sum(a_sum)
  );

  ram_read_checker #(.ERR_W(2)) dut_s (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .ram_en(s_en), .ram_addr(s_addr),
    .ram_rdata(s_rdata), .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err),
    .first_err_addr(s_first), .sum(s_sum)
  );

  ram_read_checker #(.DEPTH(1), .SEED(32'h5)) dut_d (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .ram_en(d_en), .ram_addr(d_addr),
    .ram_rdata(d_rdata), .busy(d_busy), .done(d_done), .pass(d_pass), .err_cnt(d_err),
    .first_err_addr(d_first), .sum(d_sum)
  );

  // Behavioural synchronous RAMs, one-cycle read latency.
  always @(posedge clk) if (a_en) a_rdata <= mem_a[a_addr];
  always @(posedge clk) if (s_en) s_rdata <= 32'hFFFF_FFFF;
  always @(posedge clk) if (d_en) d_rdata <= (d_addr == 6'd0) ? 32'd5 : 32'hBAD0_BAD0;

  logic       done_m [3];
  logic       en_m   [3];
  logic [5:0] addr_m [3];
  assign done_m[0] = a_done; assign en_m[0] = a_en; assign addr_m[0] = a_addr;
  assign done_m[1] = s_done; assign en_m[1] = s_en; assign addr_m[1] = s_addr;
  assign done_m[2] = d_done; assign en_m[2] = d_en; assign addr_m[2] = d_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_a();
    for (int i = 0; i < 64; i++) mem_a[i] = 32'(i);
  endtask

  // Cycle 1 is the cycle in which start is high; extra start pulses at p1..p3.
  task automatic sweep(input int sel, input int limit, input int p1, input int p2, input int p3,
                       output int done_cyc, output int n_done, output int max_addr);
    int cyc;
    done_cyc = 0;
    n_done   = 0;
    max_addr = 0;
    @(negedge clk);
    start_v[sel] = 1'b1;
    cyc = 1;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      start_v[sel] = (cyc == p1) || (cyc == p2) || (cyc == p3);
      if (done_m[sel]) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (en_m[sel] && (int'(addr_m[sel]) > max_addr)) max_addr = int'(addr_m[sel]);
    end
    start_v[sel] = 1'b0;
  endtask

  initial begin
    int dc, nd, ma, cyc;
    rst_v   = 3'b111;
    start_v = 3'b000;
    fill_a();
    repeat (3) @(negedge clk);

    // Reset state.
    check_eq("rst_ram_en",   32'(a_en),    32'd0);
    check_eq("rst_ram_addr", 32'(a_addr),  32'd0);
    check_eq("rst_busy",     32'(a_busy),  32'd0);
    check_eq("rst_done",     32'(a_done),  32'd0);
    check_eq("rst_pass",     32'(a_pass),  32'd0);
    check_eq("rst_err_cnt",  32'(a_err),   32'd0);
    check_eq("rst_first",    32'(a_first), 32'd0);
    check_eq("rst_sum",      a_sum,        32'd0);
    rst_v = 3'b000;
    @(negedge clk);

    // 1: clean sweep.
    sweep(0, 75, 0, 0, 0, dc, nd, ma);
    check_eq("t1_done_cycle", 32'(dc), 32'd67);
    check_eq("t1_done_count", 32'(nd), 32'd1);
    check_eq("t1_max_addr",   32'(ma), 32'd63);
    check_eq("t1_pass",       32'(a_pass),  32'd1);
    check_eq("t1_err_cnt",    32'(a_err),   32'd0);
    check_eq("t1_first",      32'(a_first), 32'd0);
    check_eq("t1_sum",        a_sum,        32'd2016);
    check_eq("t1_busy_after", 32'(a_busy),  32'd0);

    // 2: two corrupted words.
    mem_a[10] = 32'hDEAD;
    mem_a[40] = 32'h0;
    sweep(0, 75, 0, 0, 0, dc, nd, ma);
    check_eq("t2_done_cycle", 32'(dc), 32'd67);
    check_eq("t2_err_cnt",    32'(a_err),   32'd2);
    check_eq("t2_first",      32'(a_first), 32'd10);
    check_eq("t2_pass",       32'(a_pass),  32'd0);
    check_eq("t2_sum",        a_sum,        32'd58971);
    fill_a();

    // 3: reset in the middle of a sweep.
    @(negedge clk);
    start_v[0] = 1'b1;
    cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      start_v[0] = 1'b0;
      if (cyc == 19) begin
        check_eq("t3_busy_mid", 32'(a_busy), 32'd1);
        check_eq("t3_en_mid",   32'(a_en),   32'd1);
        check_eq("t3_addr_mid", 32'(a_addr), 32'd17);
      end
    end
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check_eq("t3_ram_en", 32'(a_en),    32'd0);
    check_eq("t3_addr",   32'(a_addr),  32'd0);
    check_eq("t3_busy",   32'(a_busy),  32'd0);
    check_eq("t3_done",   32'(a_done),  32'd0);
    check_eq("t3_pass",   32'(a_pass),  32'd0);
    check_eq("t3_err",    32'(a_err),   32'd0);
    check_eq("t3_first",  32'(a_first), 32'd0);
    check_eq("t3_sum",    a_sum,        32'd0);
    repeat (3) @(negedge clk);
    check_eq("t3_idle_busy", 32'(a_busy), 32'd0);
    check_eq("t3_idle_en",   32'(a_en),   32'd0);
    sweep(0, 75, 0, 0, 0, dc, nd, ma);
    check_eq("t3_done_cycle", 32'(dc), 32'd67);
    check_eq("t3_pass_after", 32'(a_pass), 32'd1);
    check_eq("t3_sum_after",  a_sum,       32'd2016);

    // 4: start pulses during READ, DRAIN and DONE are ignored.
    sweep(0, 140, 5, 66, 67, dc, nd, ma);
    check_eq("t4_done_cycle", 32'(dc), 32'd67);
    check_eq("t4_done_count", 32'(nd), 32'd1);
    check_eq("t4_pass",       32'(a_pass), 32'd1);
    check_eq("t4_sum",        a_sum,       32'd2016);
    check_eq("t4_busy_after", 32'(a_busy), 32'd0);

    // 5: saturating error counter.
    sweep(1, 75, 0, 0, 0, dc, nd, ma);
    check_eq("t5_done_cycle", 32'(dc), 32'd67);
    check_eq("t5_err_cnt",    32'(s_err),   32'd3);
    check_eq("t5_first",      32'(s_first), 32'd0);
    check_eq("t5_sum",        s_sum,        32'hFFFF_FFC0);
    check_eq("t5_pass",       32'(s_pass),  32'd0);

    // 6: single-word sweep.
    sweep(2, 10, 0, 0, 0, dc, nd, ma);
    check_eq("t6_done_cycle", 32'(dc), 32'd4);
    check_eq("t6_done_count", 32'(nd), 32'd1);
    check_eq("t6_max_addr",   32'(ma), 32'd0);
    check_eq("t6_pass",       32'(d_pass),  32'd1);
    check_eq("t6_err",        32'(d_err),   32'd0);
    check_eq("t6_first",      32'(d_first), 32'd0);
    check_eq("t6_sum",        d_sum,        32'd5);
    check_eq("t6_busy_after", 32'(d_busy),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
